branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit branch history counters (power of two, 4..64).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: ex_valid  input  1  instruction in EX is valid.
REQ-005 SHALL have: ex_branch  input  1  conditional branch (B-type) in EX.
REQ-006 SHALL have: ex_jump  input  1  JAL/JALR in EX.
REQ-007 SHALL have: ex_funct3  input  3  branch funct3.
REQ-008 SHALL have: ex_pc  input  32  PC of EX instruction.
REQ-009 SHALL have: ex_target  input  32  computed branch/jump target.
REQ-010 SHALL have: ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
REQ-011 SHALL have: BrEq, BrLt  input  1 each  from branch comparator.
REQ-012 SHALL have: BrUn  output  1  unsigned-compare select to branch comparator.
REQ-013 SHALL have: if_pc  input  32  fetch PC for prediction lookup.
REQ-014 SHALL have: if_pred_taken  output  1  prediction for if_pc.
REQ-015 SHALL have: redirect  output  1  fetch redirect pulse; flush  output  1  kill IF/ID and ID/EX.
REQ-016 SHALL have: redirect_pc  output  32  corrected fetch PC; mispredict_count  output  16  event counter.

Function
REQ-017 BrUn SHALL equal ex_funct3[1], combinational.
REQ-018 Actual outcome: 000 BrEq; 001 !BrEq; 100/110 BrLt; 101/111 !BrLt; 010/011 not taken and SHALL NOT update BHT; ex_jump SHALL be taken regardless of funct3.
REQ-019 Resolve event = ex_valid & (ex_branch | ex_jump) & !redirect; ex_branch and ex_jump both high SHALL be treated as jump.
REQ-020 Mispredict = resolve event & (actual != ex_pred_taken).
REQ-021 On mispredict, the next cycle SHALL have redirect=1, flush=1 for exactly one cycle; redirect_pc = ex_target if actual taken, else ex_pc+4 (mod 2^32).
REQ-022 When not asserting, redirect_pc SHALL hold its last value; redirect/flush SHALL be 0.
REQ-023 While redirect=1, EX contents are wrong-path: no resolve, no BHT update, no count, no new redirect; back-to-back redirects SHALL therefore be impossible.
REQ-024 BHT index = pc[log2(BHT_ENTRIES)+1:2]; if_pred_taken = MSB of counter[if_pc index], combinational read.
REQ-025 BHT update on resolve event with ex_branch & !ex_jump & legal funct3: taken increments saturating at 11, not taken decrements saturating at 00; write visible next cycle.
REQ-026 Same-cycle update and lookup of the same index SHALL return the pre-update value.
REQ-027 mispredict_count SHALL increment by 1 per mispredict, saturating at 16'hFFFF.

Reset
REQ-028 rst_n low SHALL immediately force redirect=0, flush=0, redirect_pc=0, mispredict_count=0, all counters=01 (weakly not-taken).
REQ-029 Reset asserted with a redirect pending SHALL cancel it; first post-reset cycle SHALL have redirect=0.

Structure
REQ-030 riscv_pkg SHALL hold the branch funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU), 2-bit counter typedef, counter constants (SNT, WNT, WT, ST).
REQ-031 Counter table SHALL be a sub-module bht_table (one read port, one write port, async reset); resolution/redirect logic stays in branch_resolve_unit.

Verification
REQ-032 After reset, if_pc=0x100 -> if_pred_taken=0; redirect=0; mispredict_count=0.
REQ-033 BEQ, BrEq=1, ex_pred_taken=0, ex_pc=0x100, ex_target=0x140 -> next cycle redirect=1, flush=1, redirect_pc=0x140, count=1; following cycle redirect=0.
REQ-034 BLTU funct3=110 -> BrUn=1; BrLt=0, pred=0 -> no redirect, counter[idx 0] 01->00, count unchanged.
REQ-035 Four taken BNE at ex_pc=0x104 -> counter 01->10->11->11 (saturates); if_pc=0x104 gives if_pred_taken=1 after first; taken BNE with pred=1 -> no redirect.
REQ-036 Mispredict in cycle N and another mispredicting branch in EX at N+1 -> second ignored (redirect single cycle, count +1 only).
REQ-037 Mispredict then rst_n low before next edge -> redirect never asserts, count=0, all counters 01.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared branch-unit definitions: B-type funct3 encodings and 2-bit saturating
// branch history counter type, constants and update rule.
package riscv_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : bht_ctr_t'(ctr + 2'b01);
        end
        return (ctr == SNT) ? SNT : bht_ctr_t'(ctr - 2'b01);
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port, one saturating-update write port; reset loads every entry weakly not-taken.
module bht_table import riscv_pkg::*; #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
    output bht_ctr_t                   o_rd_ctr,
    input  logic                       i_wr_en,
    input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
    input  logic                       i_wr_taken
);

    bht_ctr_t r_ctr [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

    // Read straight from the registers so a same-cycle write is not forwarded.
    assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX, trains the BHT, and raises a one-cycle
// redirect/flush with the corrected fetch PC on a misprediction.
module branch_resolve_unit import riscv_pkg::*; #(
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        BrEq,
    input  logic        BrLt,
    output logic        BrUn,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    br_funct3_e  w_funct3;
    logic        w_actual;
    logic        w_legal;
    logic        w_resolve;
    logic        w_mispredict;
    logic        w_bht_wr;
    logic [31:0] w_fix_pc;
    bht_ctr_t    w_rd_ctr;
    logic        w_unused;

    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic [15:0] r_count;

    assign BrUn     = ex_funct3[1];
    assign w_funct3 = br_funct3_e'(ex_funct3);

    always_comb begin
        w_actual = 1'b0;
        w_legal  = 1'b1;
        if (ex_jump) begin
            w_actual = 1'b1;
        end else begin
            unique case (w_funct3)
                BEQ:         w_actual = BrEq;
                BNE:         w_actual = ~BrEq;
                BLT, BLTU:   w_actual = BrLt;
                BGE, BGEU:   w_actual = ~BrLt;
                default:     w_legal  = 1'b0;
            endcase
        end
    end

    // EX holds a wrong-path instruction while a redirect is on the bus.
    assign w_resolve    = ex_valid & (ex_branch | ex_jump) & ~r_redirect;
    assign w_mispredict = w_resolve & (w_actual ^ ex_pred_taken);
    assign w_bht_wr     = w_resolve & ex_branch & ~ex_jump & w_legal;
    assign w_fix_pc     = w_actual ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_count       <= '0;
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_fix_pc;
                if (r_count != '1) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    bht_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (if_pc[IDX_W+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_bht_wr),
        .i_wr_idx   (ex_pc[IDX_W+1:2]),
        .i_wr_taken (w_actual)
    );

    assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], w_rd_ctr[0]};

    assign if_pred_taken    = w_rd_ctr[1];
    assign redirect         = r_redirect;
    assign flush            = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign mispredict_count = r_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_branch_resolve_unit;

    localparam int unsigned N = 16;

    logic        clk, rst_n;
    logic        ex_valid, ex_branch, ex_jump, ex_pred_taken, BrEq, BrLt;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_target, if_pc;
    logic        BrUn, if_pred_taken, redirect, flush;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int          m_ctr [N];
    bit          m_redirect;
    logic [31:0] m_rpc;
    int          m_count;

    branch_resolve_unit #(.BHT_ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .redirect(redirect), .flush(flush),
        .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit outcome(input logic jmp, input logic [2:0] f3,
                                   input logic eq, input logic lt, output bit legal);
        legal = 1'b1;
        if (jmp) return 1'b1;
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: begin legal = 1'b0; return 1'b0; end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_redirect = 1'b0;
        m_rpc      = 32'h0;
        m_count    = 0;
    endtask

    task automatic drive(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic eq, input logic lt);
        ex_valid = v; ex_branch = br; ex_jump = jmp; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; BrEq = eq; BrLt = lt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and move the model forward using the inputs held across the edge.
    task automatic tick();
        bit legal, taken, resolve, mis;
        int i;
        taken   = outcome(ex_jump, ex_funct3, BrEq, BrLt, legal);
        resolve = ex_valid && (ex_branch || ex_jump) && !m_redirect;
        mis     = resolve && (taken != ex_pred_taken);
        i       = idx_of(ex_pc);
        @(posedge clk);
        #1;
        if (resolve && ex_branch && !ex_jump && legal) begin
            if (taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else       m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
        m_redirect = mis;
        if (mis) begin
            m_rpc = taken ? ex_target : ex_pc + 32'd4;
            if (m_count < 65535) m_count++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        if_pc = 32'h100;
        #1;
        model_reset();
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL rst_redirect: got %b want 0", redirect); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush: got %b want 0", flush); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
        vectors++; if (mispredict_count !== 16'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", mispredict_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vectors++; if (if_pred_taken !== 1'b0) begin miscompares++; $display("FAIL rst_pred: got %b want 0", if_pred_taken); end
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL rst_post_redirect: got %b want 0", redirect); end
    endtask

    task automatic test_beq_mispredict();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        tick();
        vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL beq_redirect: got %b want 1", redirect); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL beq_flush: got %b want 1", flush); end
        vectors++; if (redirect_pc !== 32'h140) begin miscompares++; $display("FAIL beq_rpc: got %h want 00000140", redirect_pc); end
        vectors++; if (mispredict_count !== 16'd1) begin miscompares++; $display("FAIL beq_count: got %0d want 1", mispredict_count); end
        idle();
        tick();
        vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL beq_pulse: got %b%b want 00", redirect, flush); end
        vectors++; if (redirect_pc !== 32'h140) begin miscompares++; $display("FAIL beq_rpc_hold: got %h want 00000140", redirect_pc); end
    endtask

    task automatic test_bltu();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 3'b110, 32'h100, 32'h180, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++; if (BrUn !== 1'b1) begin miscompares++; $display("FAIL bltu_brun: got %b want 1", BrUn); end
        tick();
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL bltu_redirect: got %b want 0", redirect); end
        vectors++; if (mispredict_count !== 16'd0) begin miscompares++; $display("FAIL bltu_count: got %0d want 0", mispredict_count); end
        // Counter is now 00: one taken outcome must leave the prediction not-taken.
        drive(1'b1, 1'b1, 1'b0, 3'b110, 32'h100, 32'h180, 1'b0, 1'b0, 1'b1);
        tick();
        vectors++; if (redirect_pc !== 32'h180) begin miscompares++; $display("FAIL bltu_rpc: got %h want 00000180", redirect_pc); end
        idle();
        tick();
        if_pc = 32'h100;
        #1;
        vectors++; if (if_pred_taken !== 1'b0) begin miscompares++; $display("FAIL bltu_ctr_floor: got %b want 0", if_pred_taken); end
    endtask

    task automatic test_bne_saturate();
        do_reset();
        if_pc = 32'h104;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h104, 32'h200, (k != 0), 1'b0, 1'b0);
            tick();
            vectors++; if (redirect !== (k == 0)) begin miscompares++; $display("FAIL bne_redirect%0d: got %b want %b", k, redirect, (k == 0)); end
            if (k == 0) begin
                idle();
                tick();
            end
            #1;
            vectors++; if (if_pred_taken !== 1'b1) begin miscompares++; $display("FAIL bne_pred%0d: got %b want 1", k, if_pred_taken); end
        end
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h104, 32'h200, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (redirect_pc !== 32'h108) begin miscompares++; $display("FAIL bne_nt_rpc: got %h want 00000108", redirect_pc); end
        idle();
        tick();
        vectors++; if (if_pred_taken !== 1'b1) begin miscompares++; $display("FAIL bne_saturated: got %b want 1", if_pred_taken); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h108, 32'h300, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++; if (redirect !== 1'b1 || flush !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got %b%b want 11", redirect, flush); end
        tick();
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got %b want 0", redirect); end
        vectors++; if (mispredict_count !== 16'd1) begin miscompares++; $display("FAIL b2b_count: got %0d want 1", mispredict_count); end
        vectors++; if (redirect_pc !== 32'h140) begin miscompares++; $display("FAIL b2b_rpc: got %h want 00000140", redirect_pc); end
        idle();
        if_pc = 32'h108;
        #1;
        vectors++; if (if_pred_taken !== 1'b0) begin miscompares++; $display("FAIL b2b_no_train: got %b want 0", if_pred_taken); end
    endtask

    task automatic test_random();
        logic [31:0] pc, ipc;
        logic [2:0]  f3;
        int          kind;
        logic        pred;
        for (int n = 0; n < 600; n++) begin
            pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63)) << 2;
            ipc  = 32'($urandom_range(0, 63)) << 2;
            f3   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 3);
            pred = ($urandom_range(0, 1) == 1) ? (m_ctr[idx_of(pc)] >= 2) : 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 7) != 0), (kind == 1 || kind == 3), (kind == 2 || kind == 3), f3,
                  pc, $urandom & 32'hFFFF_FFFC, pred, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if_pc = ipc;
            #1;
            vectors++; if (BrUn !== f3[1]) begin miscompares++; $display("FAIL rnd_brun[%0d]: got %b want %b", n, BrUn, f3[1]); end
            vectors++; if (if_pred_taken !== (m_ctr[idx_of(ipc)] >= 2)) begin miscompares++; $display("FAIL rnd_pred[%0d]: got %b want %b", n, if_pred_taken, (m_ctr[idx_of(ipc)] >= 2)); end
            tick();
            vectors++; if (redirect !== m_redirect || flush !== m_redirect) begin miscompares++; $display("FAIL rnd_redirect[%0d]: got %b%b want %b", n, redirect, flush, m_redirect); end
            vectors++; if (redirect_pc !== m_rpc) begin miscompares++; $display("FAIL rnd_rpc[%0d]: got %h want %h", n, redirect_pc, m_rpc); end
            vectors++; if (int'(mispredict_count) != m_count) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, mispredict_count, m_count); end
        end
    endtask

    task automatic test_reset_cancel();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++; if (redirect !== 1'b0 || mispredict_count !== 16'd0) begin miscompares++; $display("FAIL rc_async: got %b/%0d want 0/0", redirect, mispredict_count); end
        @(posedge clk);
        #1;
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL rc_edge: got %b want 0", redirect); end
        for (int i = 0; i < N; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            vectors++; if (if_pred_taken !== 1'b0) begin miscompares++; $display("FAIL rc_ctr%0d: got %b want 0", i, if_pred_taken); end
        end
        rst_n = 1'b1;
        idle();
        tick();
        vectors++; if (redirect !== 1'b0 || mispredict_count !== 16'd0) begin miscompares++; $display("FAIL rc_post: got %b/%0d want 0/0", redirect, mispredict_count); end
        // A single taken update from 01 must flip the prediction to taken.
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h114, 32'h400, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        if_pc = 32'h114;
        #1;
        vectors++; if (if_pred_taken !== 1'b1) begin miscompares++; $display("FAIL rc_weak: got %b want 1", if_pred_taken); end
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bltu();
        test_bne_saturate();
        test_back_to_back();
        do_reset();
        test_random();
        test_reset_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
